// File: rtl/beacon_pkg.sv
// Shared types and default sizing for the beacon scan controller.
package beacon_pkg;

  localparam int DEF_CNT_W       = 16;
  localparam int DEF_MAX_BEACONS = 4;
  localparam int DEF_GAP_EDGES   = 20;

  typedef enum logic [1:0] {
    WAIT_SYNC,
    IDLE,
    BEAM,
    GAP
  } state_t;

endpackage

// File: rtl/beacon_scan_ctrl_rise_detect.sv
// Single-register rising-edge detector; the rise is combinational on the current input.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in,
  output logic rise
);

  logic r_prev;

  always_ff @(posedge clk) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= in;
  end

  assign rise = in & ~r_prev;

endmodule

// File: rtl/beacon_scan_ctrl.sv
// Turret beacon capture: tracks angle from encoder A, captures (start, end) pairs per turn
// and publishes a coherent per-turn bank on every index pulse.
module beacon_scan_ctrl
  import beacon_pkg::*;
#(
  parameter  int CNT_W       = DEF_CNT_W,
  parameter  int MAX_BEACONS = DEF_MAX_BEACONS,
  parameter  int GAP_EDGES   = DEF_GAP_EDGES,
  localparam int IDX_W       = $clog2(MAX_BEACONS),
  localparam int CNT_BW      = IDX_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync_in,
  input  logic              sign_in,
  input  logic              enc_a_in,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [CNT_W-1:0]  rd_start,
  output logic [CNT_W-1:0]  rd_end,
  output logic [CNT_BW-1:0] beacon_cnt,
  output logic [CNT_W-1:0]  turn_len,
  output logic [CNT_W-1:0]  turn_count,
  output logic              overflow,
  output logic              no_beacon,
  output logic              publish
);

  localparam logic [CNT_W-1:0]  GAP_LAST = CNT_W'(GAP_EDGES - 1);
  localparam logic [CNT_BW-1:0] SLOTS    = CNT_BW'(MAX_BEACONS);

  state_t r_state, w_state_next;

  logic              w_sync_rise, w_enc_rise;
  logic              w_active, w_turn_end, w_gap_done;
  logic              w_commit, w_room, w_fin_ovf, w_rd_valid;
  logic [CNT_W-1:0]  w_commit_end;
  logic [CNT_BW-1:0] w_fin_cnt;

  logic [CNT_W-1:0]  r_pos, r_start_tmp, r_end_tmp, r_gap_cnt;
  logic [CNT_W-1:0]  r_turn_len, r_turn_count;
  logic [CNT_BW-1:0] r_work_cnt, r_beacon_cnt;
  logic              r_work_ovf, r_overflow, r_no_beacon, r_publish;
  logic [CNT_W-1:0]  r_work_start [MAX_BEACONS];
  logic [CNT_W-1:0]  r_work_end   [MAX_BEACONS];
  logic [CNT_W-1:0]  r_pub_start  [MAX_BEACONS];
  logic [CNT_W-1:0]  r_pub_end    [MAX_BEACONS];

  rise_detect u_sync_rise (.clk(clk), .reset(reset), .in(sync_in),  .rise(w_sync_rise));
  rise_detect u_enc_rise  (.clk(clk), .reset(reset), .in(enc_a_in), .rise(w_enc_rise));

  assign w_active   = (r_state != WAIT_SYNC);
  assign w_turn_end = w_active & w_sync_rise;
  assign w_gap_done = (r_state == GAP) & ~sign_in & w_enc_rise & (r_gap_cnt == GAP_LAST);

  always_ff @(posedge clk) begin
    if (reset) r_state <= WAIT_SYNC;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      WAIT_SYNC: if (w_sync_rise) w_state_next = IDLE;
      IDLE:      if (sign_in) w_state_next = BEAM;
      BEAM:      if (!sign_in) w_state_next = GAP;
      GAP: begin
        if (sign_in)         w_state_next = BEAM;
        else if (w_gap_done) w_state_next = IDLE;
      end
      default:   w_state_next = WAIT_SYNC;
    endcase
    if (w_turn_end) w_state_next = IDLE;
  end

  // A sync rise force-closes whatever beacon is open, so it takes priority over the gap timer.
  always_comb begin
    w_commit     = 1'b0;
    w_commit_end = r_end_tmp;
    if (w_turn_end) begin
      if (r_state == BEAM) begin
        w_commit     = 1'b1;
        w_commit_end = r_pos;
      end else if (r_state == GAP) begin
        w_commit = 1'b1;
      end
    end else if (w_gap_done) begin
      w_commit = 1'b1;
    end
  end

  assign w_room    = (r_work_cnt < SLOTS);
  assign w_fin_cnt = r_work_cnt + CNT_BW'(w_commit & w_room);
  assign w_fin_ovf = r_work_ovf | (w_commit & ~w_room);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pos        <= '0;
      r_start_tmp  <= '0;
      r_end_tmp    <= '0;
      r_gap_cnt    <= '0;
      r_work_cnt   <= '0;
      r_work_ovf   <= 1'b0;
      r_turn_len   <= '0;
      r_turn_count <= '0;
      r_beacon_cnt <= '0;
      r_overflow   <= 1'b0;
      r_no_beacon  <= 1'b0;
      r_publish    <= 1'b0;
    end else begin
      if (w_sync_rise)                r_pos <= '0;
      else if (w_enc_rise & w_active) r_pos <= r_pos + 1'b1;

      if ((r_state == IDLE) & sign_in & ~w_turn_end) r_start_tmp <= r_pos;

      if ((r_state == BEAM) & ~sign_in & ~w_turn_end) begin
        r_end_tmp <= r_pos;
        r_gap_cnt <= '0;
      end else if ((r_state == GAP) & ~sign_in & w_enc_rise) begin
        r_gap_cnt <= r_gap_cnt + 1'b1;
      end

      if (w_turn_end) begin
        r_work_cnt <= '0;
        r_work_ovf <= 1'b0;
      end else if (w_commit) begin
        if (w_room) r_work_cnt <= r_work_cnt + 1'b1;
        else        r_work_ovf <= 1'b1;
      end

      r_publish <= w_turn_end;
      if (w_turn_end) begin
        r_turn_len   <= r_pos;
        r_beacon_cnt <= w_fin_cnt;
        r_overflow   <= w_fin_ovf;
        r_no_beacon  <= (w_fin_cnt == '0);
        r_turn_count <= r_turn_count + 1'b1;
      end
    end
  end

  // Each slot forwards a same-cycle commit straight into the published copy.
  generate
    for (genvar gi = 0; gi < MAX_BEACONS; gi++) begin : g_slot
      logic w_hit;
      assign w_hit = w_commit & w_room & (r_work_cnt == CNT_BW'(gi));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_work_start[gi] <= '0;
          r_work_end[gi]   <= '0;
          r_pub_start[gi]  <= '0;
          r_pub_end[gi]    <= '0;
        end else begin
          if (w_hit) begin
            r_work_start[gi] <= r_start_tmp;
            r_work_end[gi]   <= w_commit_end;
          end
          if (w_turn_end) begin
            r_pub_start[gi] <= w_hit ? r_start_tmp  : r_work_start[gi];
            r_pub_end[gi]   <= w_hit ? w_commit_end : r_work_end[gi];
          end
        end
      end
    end
  endgenerate

  assign w_rd_valid = ({1'b0, rd_idx} < r_beacon_cnt);
  assign rd_start   = w_rd_valid ? r_pub_start[rd_idx] : '0;
  assign rd_end     = w_rd_valid ? r_pub_end[rd_idx]   : '0;

  assign beacon_cnt = r_beacon_cnt;
  assign turn_len   = r_turn_len;
  assign turn_count = r_turn_count;
  assign overflow   = r_overflow;
  assign no_beacon  = r_no_beacon;
  assign publish    = r_publish;

endmodule
